// File: rtl/etapa_fetch_pc_if.sv
// rtl/etapa_fetch_pc_if.sv - instruction memory and IF/ID bus between fetch and decode
// The master side is the fetch stage, which drives the memory address and the IF/ID register.
interface etapa_fetch_pc_if #(
   parameter int N = 32
);
   logic [N-1:0] imem_addr;
   logic [31:0]  imem_data;
   logic         ifid_valid;
   logic [31:0]  ifid_instr;
   logic [N-1:0] ifid_pc4;

   modport master (
      output imem_addr,
      input  imem_data,
      output ifid_valid,
      output ifid_instr,
      output ifid_pc4
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      input  ifid_valid,
      input  ifid_instr,
      input  ifid_pc4
   );
endinterface

// File: rtl/etapa_fetch_pc.sv
// rtl/etapa_fetch_pc.sv - MIPS instruction-fetch stage: PC, next-PC select, IF/ID register
// IDLE/RUN/HALT sequencing; per RUN cycle the order is halt, redirect, stall, then sequential fetch.
module etapa_fetch_pc #(
   parameter int           N        = 32,
   parameter logic [N-1:0] RESET_PC = '0,
   parameter int           STEP     = 4,
   parameter int           CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt,
   input  logic             stall,
   input  logic             redir_valid,
   input  logic [N-1:0]     redir_pc,
   etapa_fetch_pc_if.master fbus,
   output logic [CNT_W-1:0] fetch_count,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_HALT = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     pc_q, pc_d;
   logic             ifid_valid_q, ifid_valid_d;
   logic [31:0]      ifid_instr_q, ifid_instr_d;
   logic [N-1:0]     ifid_pc4_q, ifid_pc4_d;
   logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

   logic [N-1:0] pc4;
   logic [N-1:0] redir_aligned;

   assign pc4           = pc_q + N'(STEP);
   // Branch targets are word addresses; the low two bits are discarded rather than trapped.
   assign redir_aligned = redir_pc & ~N'(3);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         ifid_valid_q  <= 1'b0;
         ifid_instr_q  <= 32'd0;
         ifid_pc4_q    <= '0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ifid_valid_q  <= ifid_valid_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_pc4_q    <= ifid_pc4_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ifid_valid_d  = ifid_valid_q;
      ifid_instr_d  = ifid_instr_q;
      ifid_pc4_d    = ifid_pc4_q;
      fetch_count_d = fetch_count_q;

      case (state_q)
         S_IDLE: begin
            pc_d         = RESET_PC;
            ifid_valid_d = 1'b0;
            ifid_instr_d = 32'd0;
            ifid_pc4_d   = '0;
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (halt) begin
               state_d      = S_HALT;
               ifid_valid_d = 1'b0;
               ifid_instr_d = 32'd0;
               ifid_pc4_d   = '0;
            end else if (redir_valid) begin
               // The instruction fetched this cycle is on the wrong path, so squash it.
               pc_d         = redir_aligned;
               ifid_valid_d = 1'b0;
               ifid_instr_d = 32'd0;
               ifid_pc4_d   = '0;
            end else if (!stall) begin
               pc_d          = pc4;
               ifid_valid_d  = 1'b1;
               ifid_instr_d  = fbus.imem_data;
               ifid_pc4_d    = pc4;
               fetch_count_d = fetch_count_q + CNT_W'(1);
            end
         end
         S_HALT: begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = 32'd0;
            ifid_pc4_d   = '0;
         end
         default: begin
            state_d      = S_IDLE;
            pc_d         = RESET_PC;
            ifid_valid_d = 1'b0;
            ifid_instr_d = 32'd0;
            ifid_pc4_d   = '0;
         end
      endcase
   end

   assign fbus.imem_addr  = pc_q;
   assign fbus.ifid_valid = ifid_valid_q;
   assign fbus.ifid_instr = ifid_instr_q;
   assign fbus.ifid_pc4   = ifid_pc4_q;
   assign fetch_count     = fetch_count_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_etapa_fetch_pc.sv
// tb/tb_etapa_fetch_pc.sv - self-checking bench for etapa_fetch_pc
// A cycle model tracks the main DUT every cycle; a second DUT exercises a wrapping RESET_PC.
module tb_etapa_fetch_pc;

   logic        clk = 1'b0;
   logic        reset, start, halt, stall, redir_valid;
   logic [31:0] redir_pc;
   logic [31:0] fetch_count;
   logic [1:0]  state_o;

   logic        reset2, start2;
   logic        zero = 1'b0;
   logic [31:0] zero32 = 32'd0;
   logic [31:0] fetch_count2;
   logic [1:0]  state2;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   etapa_fetch_pc_if #(.N(32)) bus1 ();
   etapa_fetch_pc_if #(.N(32)) bus2 ();

   assign bus1.imem_data = word(bus1.imem_addr);
   assign bus2.imem_data = word(bus2.imem_addr);

   etapa_fetch_pc #(.N(32), .RESET_PC(32'h0), .STEP(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
      .redir_valid(redir_valid), .redir_pc(redir_pc), .fbus(bus1.master),
      .fetch_count(fetch_count), .state_o(state_o)
   );

   etapa_fetch_pc #(.N(32), .RESET_PC(32'hFFFF_FFFC), .STEP(4), .CNT_W(32)) dut_wrap (
      .clk(clk), .reset(reset2), .start(start2), .halt(zero), .stall(zero),
      .redir_valid(zero), .redir_pc(zero32), .fbus(bus2.master),
      .fetch_count(fetch_count2), .state_o(state2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mode 0 idle, 1 running, 2 halted; IF/ID held as plain values.
   int          m_mode;
   logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
   logic        m_vld;

   always @(posedge clk) begin
      logic [31:0] fetched;
      fetched = word(m_pc);
      if (reset) begin
         m_mode = 0; m_pc = 0; m_vld = 0; m_instr = 0; m_pc4 = 0; m_cnt = 0;
      end else if (m_mode == 0) begin
         m_vld = 0; m_instr = 0; m_pc4 = 0; m_pc = 0;
         if (start) m_mode = 1;
      end else if (m_mode == 2) begin
         m_vld = 0; m_instr = 0; m_pc4 = 0;
      end else if (halt) begin
         m_mode = 2; m_vld = 0; m_instr = 0; m_pc4 = 0;
      end else if (redir_valid) begin
         m_pc = (redir_pc / 4) * 4;
         m_vld = 0; m_instr = 0; m_pc4 = 0;
      end else if (!stall) begin
         m_pc4 = m_pc + 4;
         m_instr = fetched;
         m_vld = 1;
         m_pc = m_pc + 4;
         m_cnt = m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_imem_addr", bus1.imem_addr, m_pc);
         check("cyc_ifid_valid", {31'd0, bus1.ifid_valid}, {31'd0, m_vld});
         check("cyc_ifid_instr", bus1.ifid_instr, m_instr);
         check("cyc_ifid_pc4", bus1.ifid_pc4, m_pc4);
         check("cyc_fetch_count", fetch_count, m_cnt);
         check("cyc_state", {30'd0, state_o}, m_mode[31:0]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset = 1; start = 0; halt = 0; stall = 0; redir_valid = 0; redir_pc = 0;
      reset2 = 1; start2 = 0;
      run_ticks(2);
      chk_en = 1'b1;
      check("rst_state", {30'd0, state_o}, 32'd0);
      check("rst_addr", bus1.imem_addr, 32'h0);
      check("rst_valid", {31'd0, bus1.ifid_valid}, 32'd0);
      check("rst_count", fetch_count, 32'd0);

      // T1 sequential fetch
      reset = 0; start = 1;
      tick();
      start = 0;
      check("t1_run", {30'd0, state_o}, 32'd1);
      tick();
      check("t1_pc4_first", bus1.ifid_pc4, 32'h4);
      check("t1_instr_first", bus1.ifid_instr, word(32'h0));
      run_ticks(2);
      check("t1_pc4_third", bus1.ifid_pc4, 32'hC);
      check("t1_count", fetch_count, 32'd3);
      tick();
      check("t1_addr_10", bus1.imem_addr, 32'h10);

      // T2 stall holds everything
      stall = 1;
      run_ticks(2);
      check("t2_addr_hold", bus1.imem_addr, 32'h10);
      check("t2_pc4_hold", bus1.ifid_pc4, 32'h10);
      check("t2_count_hold", fetch_count, 32'd4);
      stall = 0;
      tick();
      check("t2_release", bus1.ifid_pc4, 32'h14);

      // T3 redirect with misaligned target
      run_ticks(3);
      check("t3_addr_20", bus1.imem_addr, 32'h20);
      redir_valid = 1; redir_pc = 32'h103;
      tick();
      redir_valid = 0;
      check("t3_target", bus1.imem_addr, 32'h100);
      check("t3_bubble_v", {31'd0, bus1.ifid_valid}, 32'd0);
      check("t3_bubble_i", bus1.ifid_instr, 32'd0);
      tick();
      check("t3_after", bus1.ifid_pc4, 32'h104);

      // T4 redirect wins over stall
      redir_valid = 1; stall = 1; redir_pc = 32'h40;
      tick();
      redir_valid = 0; stall = 0;
      check("t4_target", bus1.imem_addr, 32'h40);
      check("t4_bubble", {31'd0, bus1.ifid_valid}, 32'd0);
      check("t4_count", fetch_count, 32'd9);

      // T6 halt is sticky until reset
      halt = 1;
      tick();
      halt = 0;
      check("t6_state", {30'd0, state_o}, 32'd2);
      check("t6_pc", bus1.imem_addr, 32'h40);
      start = 1; redir_valid = 1; redir_pc = 32'h80; stall = 1;
      run_ticks(2);
      start = 0; redir_valid = 0; stall = 0;
      check("t6_still_halt", {30'd0, state_o}, 32'd2);
      check("t6_pc_frozen", bus1.imem_addr, 32'h40);
      check("t6_valid", {31'd0, bus1.ifid_valid}, 32'd0);
      reset = 1;
      tick();
      reset = 0;
      check("t6_rst_state", {30'd0, state_o}, 32'd0);
      check("t6_rst_pc", bus1.imem_addr, 32'h0);
      check("t6_rst_count", fetch_count, 32'd0);

      // T5 PC wrap-around on the second instance
      reset2 = 0; start2 = 1;
      tick();
      start2 = 0;
      check("t5_start_pc", bus2.imem_addr, 32'hFFFF_FFFC);
      tick();
      check("t5_pc4_wrap", bus2.ifid_pc4, 32'h0);
      check("t5_valid", {31'd0, bus2.ifid_valid}, 32'd1);
      check("t5_instr", bus2.ifid_instr, word(32'hFFFF_FFFC));
      check("t5_next_pc", bus2.imem_addr, 32'h0);
      check("t5_count", fetch_count2, 32'd1);

      tick();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
